alu_bist_32bit: RTL and testbench
=================================

# alu_bist_32bit

Self-checking stimulus engine for `alu_32bit`: it drives the ALU's operand and opcode inputs and checks its result and carry outputs. On a start pulse it applies a fixed directed corner set and then LFSR-generated random vectors for ADD and SUB_SIGND. It compares every ALU response against an internal reference and reports a pass flag, an error count and the first failing vector index. It sits beside the ALU in the RISC-V core as built-in self-test and is also the hardware driver used in the ALU bring-up bench.

## Interface
- `WIDTH`, 32: operand/result width.
- `NUM_RANDOM`, 16: random vectors per opcode; legal range 0..119.
- `LFSR_SEED`, 32'hACE1_2345: LFSR load value on each accepted start; must be nonzero.
- `clk_in`  in  1: clock; all state updates on the rising edge.
- `reset_n_in`  in  1: synchronous, active-low reset.
- `start_in`  in  1: start request; sampled only in IDLE.
- `busy_out`  out  1: run in progress.
- `done_out`  out  1: one-cycle pulse at the end of a run.
- `pass_out`  out  1: 1 when the last completed run had zero errors; held until the next accepted start.
- `error_count_out`  out  8: mismatches in the current or last run; saturates at 255.
- `first_fail_index_out`  out  8: vector index of the first mismatch; 8'hFF if none.
- `operand_a_out`  out  WIDTH: to ALU `operand_a_in`; registered.
- `operand_b_out`  out  WIDTH: to ALU `operand_b_in`; registered.
- `alu_operation_out`  out  4: to ALU `alu_operation_in`; registered. ADD = 4'h0, SUB_SIGND = 4'h1.
- `result_y_in`  in  WIDTH: from ALU `result_y_out`.
- `result_carry_in`  in  1: from ALU `result_carry_out`.

## Operation
- **FSM states:** IDLE, APPLY, COMPARE, DONE.
  - IDLE with start_in=1 → APPLY. On that edge: load vector 0, reseed the LFSR, clear error_count_out, set first_fail_index_out=8'hFF, set pass_out=0.
  - APPLY → COMPARE unconditionally. This cycle is the ALU settle cycle.
  - COMPARE, on its closing edge: sample and compare the ALU response, update the error registers, then either load vector k+1 and go to APPLY, or go to DONE after the last vector.
  - DONE → IDLE. done_out=1 in this state. On this edge, pass_out takes (error_count_out==0).
- **Vector index k:** 8-bit counter, 0..N-1 with N = 2·(8+NUM_RANDOM). Order is ADD directed, ADD random, SUB directed, SUB random.
- **Directed set, per opcode, in order:** (0,0), (1,0), (0,1), (2,1), (32'hFFFF,1), (1,32'hFFFF), (32'hFFFF_FFFF,32'hFFFF_FFFF), (32'hFFFF_FF9C,32'hFFFF_FFFE).
- **Random vectors:**
  - LFSR is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - a = current LFSR state; b = its one-step successor.
  - The LFSR advances two steps per random vector.
  - It is reseeded only on start, not between opcodes.
- **Reference model:**
  - ADD: expected {carry,y} = a + b, computed at WIDTH+1 bits. Both y and carry are compared.
  - SUB_SIGND: expected y = (a − b) mod 2^WIDTH. Carry is not compared.
- **On mismatch:**
  - error_count_out increments unless it is already 255.
  - If this is the first error of the run, first_fail_index_out = k.
- **start_in handling:** ignored in APPLY, COMPARE and DONE. A start held high continuously causes a new run on each return to IDLE.

## Timing
- **Reset values:** busy_out=0, done_out=0, pass_out=0, error_count_out=0, first_fail_index_out=8'hFF, operand_a_out=0, operand_b_out=0, alu_operation_out=4'h0. FSM in IDLE, LFSR = LFSR_SEED.
- **Start:** start accepted at edge E0 → busy_out=1 and vector 0 on the outputs from E0 until E2.
- **Per vector:** 2 cycles. Vector k is driven from edge E0+2k and compared at edge E0+2k+2.
- **Busy:** busy_out is high for exactly 2N cycles. The default configuration (N=48) gives 96 cycles.
- **Done:** done_out is high for the single cycle after busy_out falls. Error outputs are final when done_out=1; pass_out is valid from the following cycle.
- **ALU path:** the ALU is combinational, so the result must settle within APPLY plus COMPARE.
- **Reset mid-run:** reset_n_in=0 at any edge returns every output to its reset value. No done_out pulse is produced.
- **Operand hold:** operands hold the last vector after a run until the next start or reset.

## Test plan
- **Reset:** hold reset_n_in=0 for 3 cycles → all outputs at the reset values above. start_in pulsed during reset is ignored.
- **Healthy ALU, defaults:** connect `alu_32bit` and pulse start → busy_out for 96 cycles, then done_out for 1 cycle. Final outputs: error_count_out=0, first_fail_index_out=8'hFF, pass_out=1.
- **Single-bit fault:** invert result_y_in[0] only while k=3 → error_count_out=1, first_fail_index_out=3, pass_out=0.
- **Stuck-at-zero ALU:** NUM_RANDOM=0, result_y_in=0, result_carry_in=0 → busy_out for 32 cycles. Final outputs: error_count_out=13 (ADD k=1..7; SUB k=9..12, 13, 15), first_fail_index_out=1, pass_out=0.
- **Start handling:** start_in pulsed during busy → no effect. A second start after done → identical operand sequence (check vector 8 a/b against the first run) and identical results.
- **Reset mid-run:** reset_n_in=0 at vector 10 → reset values and no done_out. A following start completes normally with pass_out=1.

Source files
------------

// File: rtl/alu_bist_32bit_if.sv
// ALU-side bus of the BIST engine: operands/opcode out to the ALU, result/carry back.
// Handshake: none on this bus; the engine holds operands stable for two cycles per vector
// (APPLY then COMPARE) and samples result_y_in/result_carry_in on the COMPARE closing edge.
interface alu_bist_32bit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] operand_a_out;
    logic [WIDTH-1:0] operand_b_out;
    logic [3:0]       alu_operation_out;
    logic [WIDTH-1:0] result_y_in;
    logic             result_carry_in;

    modport master (
        output operand_a_out,
        output operand_b_out,
        output alu_operation_out,
        input  result_y_in,
        input  result_carry_in
    );

    modport slave (
        input  operand_a_out,
        input  operand_b_out,
        input  alu_operation_out,
        output result_y_in,
        output result_carry_in
    );
endinterface

// File: rtl/alu_bist_32bit.sv
// Built-in self-test engine for alu_32bit: directed corners then LFSR vectors for ADD and SUB_SIGND,
// checked against an internal reference; reports pass flag, error count and first failing index.
module alu_bist_32bit #(
    parameter int          WIDTH      = 32,
    parameter int          NUM_RANDOM = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic                 start_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 pass_out,
    output logic [7:0]           error_count_out,
    output logic [7:0]           first_fail_index_out,
    output logic [1:0]           state_out,
    alu_bist_32bit_if.master     alu_bus
);
    localparam int          PER_OP    = 8 + NUM_RANDOM;
    localparam int          NUM_VEC   = 2 * PER_OP;
    localparam logic [7:0]  PER_OP_K  = 8'(PER_OP);
    localparam logic [7:0]  LAST_K    = 8'(NUM_VEC - 1);
    localparam logic [3:0]  OP_ADD    = 4'h0;
    localparam logic [3:0]  OP_SUB    = 4'h1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COMPARE, S_DONE} state_t;

    state_t      state;
    logic [7:0]  k;
    logic [31:0] lfsr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    function automatic logic [2*WIDTH-1:0] directed_ab(input logic [2:0] i);
        logic [31:0] a;
        logic [31:0] b;
        case (i)
            3'd0:    begin a = 32'h0;         b = 32'h0;         end
            3'd1:    begin a = 32'h1;         b = 32'h0;         end
            3'd2:    begin a = 32'h0;         b = 32'h1;         end
            3'd3:    begin a = 32'h2;         b = 32'h1;         end
            3'd4:    begin a = 32'hFFFF;      b = 32'h1;         end
            3'd5:    begin a = 32'h1;         b = 32'hFFFF;      end
            3'd6:    begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            default: begin a = 32'hFFFF_FF9C; b = 32'hFFFF_FFFE; end
        endcase
        return {WIDTH'(a), WIDTH'(b)};
    endfunction

    // Next-vector generation: index k+1 is split into opcode half and position within it.
    logic [7:0]       next_k;
    logic             next_in_sub;
    logic [7:0]       next_pos;
    logic             next_is_rand;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic [3:0]       next_op;
    logic [31:0]      lfsr_succ;

    always_comb begin
        next_k       = k + 8'd1;
        next_in_sub  = (next_k >= PER_OP_K);
        next_pos     = next_in_sub ? (next_k - PER_OP_K) : next_k;
        next_is_rand = (next_pos >= 8'd8);
        next_op      = next_in_sub ? OP_SUB : OP_ADD;
        lfsr_succ    = lfsr_step(lfsr);
        if (next_is_rand) begin
            next_a = WIDTH'(lfsr);
            next_b = WIDTH'(lfsr_succ);
        end else begin
            {next_a, next_b} = directed_ab(next_pos[2:0]);
        end
    end

    // Reference: ADD checks carry and sum, SUB_SIGND checks only the wrapped difference.
    logic [WIDTH:0]   ref_sum;
    logic [WIDTH-1:0] ref_diff;
    logic             mismatch;

    always_comb begin
        ref_sum  = {1'b0, alu_bus.operand_a_out} + {1'b0, alu_bus.operand_b_out};
        ref_diff = alu_bus.operand_a_out - alu_bus.operand_b_out;
        if (alu_bus.alu_operation_out == OP_ADD) begin
            mismatch = (ref_sum != {alu_bus.result_carry_in, alu_bus.result_y_in});
        end else begin
            mismatch = (ref_diff != alu_bus.result_y_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state                     <= S_IDLE;
            k                         <= 8'd0;
            lfsr                      <= LFSR_SEED;
            busy_out                  <= 1'b0;
            done_out                  <= 1'b0;
            pass_out                  <= 1'b0;
            error_count_out           <= 8'd0;
            first_fail_index_out      <= 8'hFF;
            alu_bus.operand_a_out     <= '0;
            alu_bus.operand_b_out     <= '0;
            alu_bus.alu_operation_out <= OP_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state                     <= S_APPLY;
                        busy_out                  <= 1'b1;
                        k                         <= 8'd0;
                        lfsr                      <= LFSR_SEED;
                        error_count_out           <= 8'd0;
                        first_fail_index_out      <= 8'hFF;
                        pass_out                  <= 1'b0;
                        {alu_bus.operand_a_out, alu_bus.operand_b_out} <= directed_ab(3'd0);
                        alu_bus.alu_operation_out <= OP_ADD;
                    end
                end
                S_APPLY: begin
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (mismatch) begin
                        if (error_count_out != 8'hFF) begin
                            error_count_out <= error_count_out + 8'd1;
                        end
                        if (error_count_out == 8'd0) begin
                            first_fail_index_out <= k;
                        end
                    end
                    if (k == LAST_K) begin
                        state    <= S_DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        state                     <= S_APPLY;
                        k                         <= next_k;
                        alu_bus.operand_a_out     <= next_a;
                        alu_bus.operand_b_out     <= next_b;
                        alu_bus.alu_operation_out <= next_op;
                        if (next_is_rand) begin
                            lfsr <= lfsr_step(lfsr_succ);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    done_out <= 1'b0;
                    pass_out <= (error_count_out == 8'd0);
                end
            endcase
        end
    end

    assign state_out = state;
endmodule

// File: tb/tb_alu_bist_32bit.sv
// Bench for alu_bist_32bit: a behavioural ALU with injectable faults drives one default DUT,
// a stuck-at-zero bus drives a NUM_RANDOM=0 DUT; expected vectors come from a list model.
module tb_alu_bist_32bit;
    localparam int          W    = 32;
    localparam int          NR   = 16;
    localparam int          NV   = 2 * (8 + NR);
    localparam int          NV1  = 16;
    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       start1;
    logic       busy, done, pass;
    logic [7:0] errc, ffi;
    logic [1:0] st;
    logic       busy1, done1, pass1;
    logic [7:0] errc1, ffi1;
    logic [1:0] st1;

    alu_bist_32bit_if #(.WIDTH(W)) bus0 ();
    alu_bist_32bit_if #(.WIDTH(W)) bus1 ();

    alu_bist_32bit dut0 (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start),
        .busy_out(busy), .done_out(done), .pass_out(pass),
        .error_count_out(errc), .first_fail_index_out(ffi),
        .state_out(st), .alu_bus(bus0.master)
    );

    alu_bist_32bit #(.NUM_RANDOM(0)) dut1 (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start1),
        .busy_out(busy1), .done_out(done1), .pass_out(pass1),
        .error_count_out(errc1), .first_fail_index_out(ffi1),
        .state_out(st1), .alu_bus(bus1.master)
    );

    assign bus1.result_y_in     = '0;
    assign bus1.result_carry_in = 1'b0;

    // Vector list model and fault controls
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [3:0]  vo [NV];
    logic        bad [NV];
    logic        carry_fault;
    logic [67:0] exp_q [$];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic build_list();
        logic [31:0] da [8];
        logic [31:0] db [8];
        logic [31:0] s;
        int          n;
        da = '{32'h0, 32'h1, 32'h0, 32'h2, 32'hFFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
        db = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        s = SEED;
        n = 0;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 8; i++) begin
                va[n] = da[i]; vb[n] = db[i]; vo[n] = 4'(op); n++;
            end
            for (int r = 0; r < NR; r++) begin
                va[n] = s; vb[n] = lfsr_next(s); vo[n] = 4'(op); n++;
                s = lfsr_next(lfsr_next(s));
            end
        end
    endtask

    // Behavioural ALU: identifies the vector on the bus to apply per-vector faults
    logic [31:0] alu_y;
    logic        alu_c;
    logic [63:0] sum64;
    int          hit;

    always_comb begin
        hit   = -1;
        sum64 = 64'(bus0.operand_a_out) + 64'(bus0.operand_b_out);
        for (int j = 0; j < NV; j++) begin
            if (hit < 0 && vo[j] == bus0.alu_operation_out &&
                va[j] == bus0.operand_a_out && vb[j] == bus0.operand_b_out) begin
                hit = j;
            end
        end
        if (bus0.alu_operation_out == 4'h0) begin
            alu_y = sum64[31:0];
            alu_c = sum64[32];
        end else begin
            alu_y = bus0.operand_a_out - bus0.operand_b_out;
            alu_c = (bus0.operand_a_out >= bus0.operand_b_out);
        end
        if (hit >= 0 && bad[hit]) alu_y[0] = ~alu_y[0];
        if (carry_fault) alu_c = ~alu_c;
    end

    assign bus0.result_y_in     = alu_y;
    assign bus0.result_carry_in = alu_c;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, 68'(busy), 68'(0));
        check({tag, " done"}, 68'(done), 68'(0));
        check({tag, " pass"}, 68'(pass), 68'(0));
        check({tag, " errc"}, 68'(errc), 68'(0));
        check({tag, " ffi"}, 68'(ffi), 68'hFF);
        check({tag, " ops"}, {bus0.alu_operation_out, bus0.operand_a_out, bus0.operand_b_out}, 68'(0));
        check({tag, " state"}, 68'(st), 68'(0));
        check({tag, " dut1 busy/errc/ffi"}, {busy1, errc1, ffi1}, {1'b0, 8'd0, 8'hFF});
    endtask

    // One full run on dut0, checking each driven vector, busy/done timing and final status
    task automatic run0(input string tag, input logic [7:0] e_err, input logic [7:0] e_ff,
                        input logic e_pass, input int pulse_mid);
        int busy_cnt, done_cnt, done_at;
        logic [67:0] item;
        exp_q.delete();
        for (int i = 0; i < NV; i++) exp_q.push_back({vo[i], va[i], vb[i]});
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 2 * NV + 2; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == pulse_mid);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = c; end
            if (c < 2 * NV && (c % 2) == 0 && exp_q.size() > 0) begin
                item = exp_q.pop_front();
                if ({bus0.alu_operation_out, bus0.operand_a_out, bus0.operand_b_out} !== item)
                    check($sformatf("%s vec%0d", tag, c / 2),
                          {bus0.alu_operation_out, bus0.operand_a_out, bus0.operand_b_out}, item);
            end
            if (c == 2 * NV) begin
                check({tag, " errc"}, 68'(errc), 68'(e_err));
                check({tag, " ffi"}, 68'(ffi), 68'(e_ff));
            end
            if (c == 2 * NV + 1) check({tag, " pass"}, 68'(pass), 68'(e_pass));
        end
        start = 1'b0;
        check({tag, " vectors left"}, 68'(exp_q.size()), 68'(0));
        check({tag, " busy cycles"}, 68'(busy_cnt), 68'(2 * NV));
        check({tag, " done cycles"}, 68'(done_cnt), 68'(1));
        check({tag, " done position"}, 68'(done_at), 68'(2 * NV));
        check({tag, " last vector held"}, {bus0.alu_operation_out, bus0.operand_a_out, bus0.operand_b_out},
              {vo[NV-1], va[NV-1], vb[NV-1]});
    endtask

    typedef struct {
        string      name;
        int         mode;     // 0 healthy, 1 single y fault, 2 carry fault, 3 random y faults
        int         idx;
        logic [7:0] e_err;
        logic [7:0] e_ff;
        logic       e_pass;
        int         pulse_mid;
    } run_t;

    run_t runs [6];
    logic rmask [NV];

    initial begin
        int cnt, first, r, busy1_cnt, done_seen;
        build_list();
        carry_fault = 1'b0;
        for (int i = 0; i < NV; i++) bad[i] = 1'b0;

        r = $urandom_range(8, NV - 1);
        cnt = 0; first = 255;
        for (int i = 0; i < NV; i++) begin
            rmask[i] = ($urandom_range(0, 3) == 0);
            if (rmask[i]) begin cnt++; if (first == 255) first = i; end
        end
        runs[0] = '{"healthy", 0, 0, 8'd0, 8'hFF, 1'b1, 21};
        runs[1] = '{"fault_k3", 1, 3, 8'd1, 8'd3, 1'b0, -1};
        runs[2] = '{"fault_rand_k", 1, r, 8'd1, 8'(r), 1'b0, -1};
        runs[3] = '{"carry_fault", 2, 0, 8'(8 + NR), 8'd0, 1'b0, -1};
        runs[4] = '{"rand_mask", 3, 0, 8'(cnt), 8'(first), (cnt == 0), 40};
        runs[5] = '{"healthy_again", 0, 0, 8'd0, 8'hFF, 1'b1, -1};

        reset_n = 1'b0; start = 1'b1; start1 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        start = 1'b0; start1 = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("after reset");

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NV; i++) bad[i] = 1'b0;
            carry_fault = 1'b0;
            case (runs[t].mode)
                1: bad[runs[t].idx] = 1'b1;
                2: carry_fault = 1'b1;
                3: for (int i = 0; i < NV; i++) bad[i] = rmask[i];
                default: ;
            endcase
            run0(runs[t].name, runs[t].e_err, runs[t].e_ff, runs[t].e_pass, runs[t].pulse_mid);
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < NV; i++) bad[i] = 1'b0;
        carry_fault = 1'b0;

        // Reset in the middle of a run, while vector 10 is on the bus
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        check("midrun vec10 a", 68'(bus0.operand_a_out), 68'(va[10]));
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrun reset");
        reset_n = 1'b1;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrun no done", 68'(done_seen), 68'(0));
        check("midrun idle busy", 68'(busy), 68'(0));
        run0("after midrun", 8'd0, 8'hFF, 1'b1, -1);

        // Stuck-at-zero ALU on the NUM_RANDOM=0 instance
        busy1_cnt = 0; done_seen = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int c = 0; c < 2 * NV1 + 10; c++) begin
            if (c > 0) @(negedge clk);
            if (busy1) busy1_cnt++;
            if (done1) begin
                done_seen++;
                check("stuck errc", 68'(errc1), 68'd13);
                check("stuck ffi", 68'(ffi1), 68'd1);
            end
        end
        check("stuck busy cycles", 68'(busy1_cnt), 68'(2 * NV1));
        check("stuck done cycles", 68'(done_seen), 68'(1));
        check("stuck pass", 68'(pass1), 68'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
